// File: rtl/irq_pkg.sv
// Shared types and defaults for the nested-interrupt sequencer.
// Level 0 means "no irq in service"; level k means irq k-1 is in service.
package irq_pkg;

  localparam int IRQ_CNT = 3;
  localparam int LVL_W   = $clog2(IRQ_CNT + 1);

  typedef logic [LVL_W-1:0] level_t;

  localparam logic CSR_SEL_IE   = 1'b0;
  localparam logic CSR_SEL_MASK = 1'b1;

  localparam logic [31:0] DEF_VEC_BASE  = 32'h0000_0100;
  localparam int          DEF_VEC_SHIFT = 6;
  localparam logic [31:0] DEF_ECALL_VEC = 32'h0000_0080;

  typedef struct packed {
    logic [31:0] epc;
    level_t      prev_level;
  } stack_entry_t;

endpackage

// File: rtl/irq_sync_edge.sv
// Synchroniser chain for one asynchronous request line, followed by a
// rising-edge detector that emits a single-cycle pulse.
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_p;
  logic                   prev_p;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p <= '0;
      prev_p <= 1'b0;
    end else begin
      sync_p <= {sync_p[SYNC_STAGES-2:0], din};
      prev_p <= sync_p[SYNC_STAGES-1];
    end
  end

  assign pulse = sync_p[SYNC_STAGES-1] & ~prev_p;

endmodule

// File: rtl/irq_nest_sequencer.sv
// Nested-interrupt sequencer: prioritises ecall > uret > irq, drives a
// same-cycle PC redirect and keeps an EPC/level stack for pre-emption.
module irq_nest_sequencer
  import irq_pkg::*;
#(
  parameter int          N_IRQ       = IRQ_CNT,
  parameter int          NEST_DEPTH  = 4,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] VEC_BASE    = DEF_VEC_BASE,
  parameter int          VEC_SHIFT   = DEF_VEC_SHIFT,
  parameter logic [31:0] ECALL_VEC   = DEF_ECALL_VEC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             ecall,
  input  logic             uret,
  input  logic             halt,
  input  logic [31:0]      pc_next,
  input  logic             csr_we,
  input  logic             csr_sel,
  input  logic [31:0]      csr_wdata,
  output logic [31:0]      csr_rdata,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic [N_IRQ-1:0] in_service,
  output logic [N_IRQ-1:0] pending,
  output logic             stack_err
);

  localparam int SP_W  = $clog2(NEST_DEPTH + 1);
  localparam int IDX_W = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(NEST_DEPTH);

  function automatic logic [31:0] vec_addr(input int idx);
    return VEC_BASE + (32'(idx) << VEC_SHIFT);
  endfunction

  logic [N_IRQ-1:0] edge_pulse;
  logic [N_IRQ-1:0] pending_q;
  logic [N_IRQ-1:0] mask_q;
  logic             ie_q;
  level_t           cur_level;
  logic [SP_W-1:0]  sp;
  logic             stack_err_q;
  stack_entry_t     stack_q [2**IDX_W];

  logic             stack_full, stack_empty;
  logic [SP_W-1:0]  sp_dec;
  stack_entry_t     top_entry;

  logic             take_vld;
  level_t           take_lvl;
  logic [N_IRQ-1:0] take_oh;
  logic [31:0]      take_pc;

  logic             do_push, do_pop, err_set, take_irq, redir;
  logic [31:0]      redir_pc;
  level_t           level_nxt;
  logic             unused_wdata;

  for (genvar g = 0; g < N_IRQ; g++) begin : g_sync
    irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .rst   (rst),
      .din   (irq_in[g]),
      .pulse (edge_pulse[g])
    );
  end

  assign stack_full  = (sp == SP_FULL);
  assign stack_empty = (sp == '0);
  assign sp_dec      = sp - SP_W'(1);
  assign top_entry   = stack_q[sp_dec[IDX_W-1:0]];

  // Highest eligible index wins; only strictly higher levels may pre-empt.
  always_comb begin
    take_vld = 1'b0;
    take_lvl = '0;
    take_oh  = '0;
    take_pc  = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (pending_q[i] && mask_q[i] && ie_q && !halt && !stack_full &&
          (LVL_W'(i + 1) > cur_level)) begin
        take_vld    = 1'b1;
        take_lvl    = LVL_W'(i + 1);
        take_oh     = '0;
        take_oh[i]  = 1'b1;
        take_pc     = vec_addr(i);
      end
    end
  end

  always_comb begin
    do_push   = 1'b0;
    do_pop    = 1'b0;
    err_set   = 1'b0;
    take_irq  = 1'b0;
    redir     = 1'b0;
    redir_pc  = '0;
    level_nxt = cur_level;
    if (ecall) begin
      if (!stack_full) begin
        redir    = 1'b1;
        redir_pc = ECALL_VEC;
        do_push  = 1'b1;
      end else begin
        err_set  = 1'b1;
      end
    end else if (uret) begin
      if (!stack_empty) begin
        redir     = 1'b1;
        redir_pc  = top_entry.epc;
        do_pop    = 1'b1;
        level_nxt = top_entry.prev_level;
      end else begin
        err_set   = 1'b1;
      end
    end else if (take_vld) begin
      redir     = 1'b1;
      redir_pc  = take_pc;
      do_push   = 1'b1;
      take_irq  = 1'b1;
      level_nxt = take_lvl;
    end
  end

  // A fresh edge in the same cycle as a take keeps the request pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q   <= '0;
      ie_q        <= 1'b0;
      mask_q      <= '0;
      cur_level   <= '0;
      sp          <= '0;
      stack_err_q <= 1'b0;
    end else begin
      pending_q   <= (pending_q & ~(take_irq ? take_oh : '0)) | edge_pulse;
      if (csr_we) begin
        if (csr_sel == CSR_SEL_IE) ie_q   <= csr_wdata[0];
        else                       mask_q <= csr_wdata[N_IRQ-1:0];
      end
      cur_level   <= level_nxt;
      if (do_push)     sp <= sp + SP_W'(1);
      else if (do_pop) sp <= sp_dec;
      stack_err_q <= stack_err_q | err_set;
    end
  end

  // Stack contents are data only; sp alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) stack_q[sp[IDX_W-1:0]] <= '{epc: pc_next, prev_level: cur_level};
  end

  always_comb begin
    in_service = '0;
    for (int i = 0; i < N_IRQ; i++) in_service[i] = (cur_level == LVL_W'(i + 1));
  end

  assign csr_rdata    = (csr_sel == CSR_SEL_IE) ? {31'b0, ie_q} : 32'(mask_q);
  assign pending      = pending_q;
  assign stack_err    = stack_err_q;
  assign redirect     = redir & ~rst;
  assign redirect_pc  = redirect ? redir_pc : '0;
  assign unused_wdata = ^csr_wdata;

  ecall_uret_exclusive: assert property (@(posedge clk) disable iff (rst) !(ecall && uret));

endmodule
